// File: rtl/multicycle_cu.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXEC/MEM/WB with imem/dmem wait-state handshakes,
// single-step debug pause, illegal-opcode trap and saturating cycle/retired-instruction counters.
module multicycle_cu #(
    parameter int PC_W     = 10,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_mode,
    input  logic             step,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    input  logic             alu_zero,
    output logic [31:0]      instr,
    output logic [2:0]       alu_op,
    output logic             alu_src_imm,
    output logic             reg_dst_rd,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic [PC_W-1:0]  pc,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);
    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_STEP, S_HALT
    } state_t;

    localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_J = 6'h02, OP_HALT = 6'h3F;

    state_t           state_q, state_d, after_retire;
    logic [PC_W-1:0]  pc_q, pc_d, br_off;
    logic [31:0]      instr_q, instr_d;
    logic [2:0]       alu_op_q, alu_op_d;
    logic             src_imm_q, src_imm_d, reg_dst_q, reg_dst_d, m2r_q, m2r_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, icnt_q, icnt_d;

    logic [5:0] opc, fn;
    logic       dec_legal, dec_imm, dec_rd, dec_m2r;
    logic [2:0] dec_op;
    logic       is_br, is_j, is_mem, is_sw, br_taken, retire;

    assign opc      = instr_q[31:26];
    assign fn       = instr_q[5:0];
    assign is_br    = (opc == OP_BEQ) || (opc == OP_BNE);
    assign is_j     = (opc == OP_J);
    assign is_sw    = (opc == OP_SW);
    assign is_mem   = (opc == OP_LW) || is_sw;
    assign br_taken = (opc == OP_BEQ) ? alu_zero : !alu_zero;
    // pc already points past the branch, so the offset is applied to pc_q directly
    assign br_off   = PC_W'($signed(instr_q[15:0]));
    assign after_retire = step_mode ? S_STEP : S_FETCH;
    assign retire   = ((state_q == S_EXEC) && (is_br || is_j))
                   || ((state_q == S_MEM) && dmem_ack && is_sw)
                   || (state_q == S_WB);

    always_comb begin
        dec_legal = 1'b1;
        dec_op    = 3'd0;
        dec_imm   = 1'b0;
        dec_rd    = 1'b0;
        dec_m2r   = 1'b0;
        case (opc)
            OP_R: begin
                dec_rd = 1'b1;
                case (fn)
                    6'h20:   dec_op = 3'd0;
                    6'h22:   dec_op = 3'd1;
                    6'h24:   dec_op = 3'd2;
                    6'h25:   dec_op = 3'd3;
                    6'h2A:   dec_op = 3'd4;
                    default: dec_legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_SW:  dec_imm = 1'b1;
            OP_LW: begin
                dec_imm = 1'b1;
                dec_m2r = 1'b1;
            end
            OP_BEQ, OP_BNE:  dec_op = 3'd1;
            OP_J, OP_HALT:   dec_op = 3'd0;
            default:         dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (imem_ack) state_d = S_DECODE;
            S_DECODE: state_d = (!dec_legal || opc == OP_HALT) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (is_br || is_j) state_d = after_retire;
                else if (is_mem)   state_d = S_MEM;
                else               state_d = S_WB;
            end
            S_MEM:    if (dmem_ack) state_d = is_sw ? after_retire : S_WB;
            S_WB:     state_d = after_retire;
            S_STEP:   if (step) state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_write = 1'b0;
        halted    = 1'b0;
        case (state_q)
            S_FETCH: imem_req = 1'b1;
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
            end
            S_WB:    reg_write = 1'b1;
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        pc_d      = pc_q;
        instr_d   = instr_q;
        alu_op_d  = alu_op_q;
        src_imm_d = src_imm_q;
        reg_dst_d = reg_dst_q;
        m2r_d     = m2r_q;
        illegal_d = illegal_q;
        cyc_d     = cyc_q;
        icnt_d    = icnt_q;
        if (state_q == S_FETCH && imem_ack) begin
            instr_d = imem_rdata;
            pc_d    = pc_q + PC_W'(1);
        end
        if (state_q == S_DECODE) begin
            alu_op_d  = dec_op;
            src_imm_d = dec_imm;
            reg_dst_d = dec_rd;
            m2r_d     = dec_m2r;
            if (!dec_legal) illegal_d = 1'b1;
        end
        if (state_q == S_EXEC) begin
            if (is_j)                  pc_d = instr_q[PC_W-1:0];
            else if (is_br && br_taken) pc_d = pc_q + br_off;
        end
        if (state_q != S_HALT && cyc_q != {CNT_W{1'b1}}) cyc_d = cyc_q + CNT_W'(1);
        if (retire && icnt_q != {CNT_W{1'b1}})           icnt_d = icnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= PC_W'(RESET_PC);
            instr_q   <= 32'd0;
            alu_op_q  <= 3'd0;
            src_imm_q <= 1'b0;
            reg_dst_q <= 1'b0;
            m2r_q     <= 1'b0;
            illegal_q <= 1'b0;
            cyc_q     <= '0;
            icnt_q    <= '0;
        end else begin
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            alu_op_q  <= alu_op_d;
            src_imm_q <= src_imm_d;
            reg_dst_q <= reg_dst_d;
            m2r_q     <= m2r_d;
            illegal_q <= illegal_d;
            cyc_q     <= cyc_d;
            icnt_q    <= icnt_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instr       = instr_q;
    assign alu_op      = alu_op_q;
    assign alu_src_imm = src_imm_q;
    assign reg_dst_rd  = reg_dst_q;
    assign mem_to_reg  = m2r_q;
    assign illegal     = illegal_q;
    assign cycle_count = cyc_q;
    assign instr_count = icnt_q;
endmodule
